// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one iteration per clock,
// valid/ready handshake on both the binary input and the BCD output.
module bin2bcd_seq #(
    parameter int WIDTH  = 8,
    parameter int DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic                busy
);

    // state | meaning
    // IDLE  | waiting for in_valid, in_ready=1
    // SHIFT | one add-3/shift iteration per clock, busy=1
    // DONE  | result held on bcd, out_valid=1 until out_ready
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int IW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;
    localparam logic [IW-1:0] LAST = IW'(WIDTH - 1);
    localparam longint unsigned BCD_RANGE = 64'd10 ** DIGITS;
    localparam longint unsigned BIN_RANGE = 64'd1 << WIDTH;

    generate
        if (BCD_RANGE < BIN_RANGE) begin : g_range_check
            $error("bin2bcd_seq: DIGITS too small to represent 2**WIDTH-1");
        end
    endgenerate

    state_t           state, state_nx;
    logic [WIDTH-1:0] shreg, shreg_nx;
    logic [BW-1:0]    work, work_nx, adj, work_sh;
    logic [BW-1:0]    bcd_nx;
    logic [IW-1:0]    iter, iter_nx;

    // Add-3 is confined to each nibble; no carry propagates between digits.
    always_comb begin
        adj = work;
        for (int d = 0; d < DIGITS; d++) begin
            if (work[4*d +: 4] >= 4'd5)
                adj[4*d +: 4] = work[4*d +: 4] + 4'd3;
        end
        work_sh = {adj[BW-2:0], shreg[WIDTH-1]};
    end

    always_comb begin
        state_nx = state;
        shreg_nx = shreg;
        work_nx  = work;
        iter_nx  = iter;
        bcd_nx   = bcd;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    shreg_nx = bin;
                    work_nx  = '0;
                    iter_nx  = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                work_nx  = work_sh;
                shreg_nx = shreg << 1;
                iter_nx  = iter + 1'b1;
                if (iter == LAST) begin
                    bcd_nx   = work_sh;
                    state_nx = DONE;
                end
            end
            DONE: begin
                if (out_ready)
                    state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            shreg <= '0;
            work  <= '0;
            iter  <= '0;
            bcd   <= '0;
        end else begin
            state <= state_nx;
            shreg <= shreg_nx;
            work  <= work_nx;
            iter  <= iter_nx;
            bcd   <= bcd_nx;
        end
    end

    // Gated by rst so the producer never sees ready while the block is held in reset.
    assign in_ready  = (state == IDLE) && rst;
    assign out_valid = (state == DONE);
    assign busy      = (state == SHIFT);

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed self-checking bench for bin2bcd_seq: an 8-bit/3-digit instance and a
// 4-bit/2-digit instance, checked against a divide-by-ten reference.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;

    logic        in_valid, in_ready, out_valid, out_ready, busy;
    logic [7:0]  bin;
    logic [11:0] bcd;

    logic        in_valid4, in_ready4, out_valid4, out_ready4, busy4;
    logic [3:0]  bin4;
    logic [7:0]  bcd4;

    int ntests = 0;
    int nfail  = 0;
    int cyc    = 0;

    bin2bcd_seq #(.WIDTH(8), .DIGITS(3)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .bin(bin),
        .out_valid(out_valid), .out_ready(out_ready), .bcd(bcd), .busy(busy)
    );

    bin2bcd_seq #(.WIDTH(4), .DIGITS(2)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .bin(bin4),
        .out_valid(out_valid4), .out_ready(out_ready4), .bcd(bcd4), .busy(busy4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ref_bcd(input int v);
        logic [31:0] r;
        int          x;
        r = '0;
        x = v;
        for (int i = 0; i < 8; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; returns number of posedges until out_valid (bounded).
    task automatic wait8(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(posedge clk); n++; @(negedge clk);
        end
    endtask

    task automatic wait4(output int n);
        n = 0;
        while (out_valid4 !== 1'b1 && n < 40) begin
            @(posedge clk); n++; @(negedge clk);
        end
    endtask

    // Accept v, wait for completion, check latency (edges counted including the
    // accept edge) and value. Leaves the result pending in DONE.
    task automatic conv8(input logic [7:0] v, input string tag);
        int n;
        check({tag, " ready_before"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; bin = v;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        check({tag, " ready_drop"}, 32'(in_ready), 32'd0);
        wait8(n);
        check({tag, " latency"}, 32'(n + 1), 32'd9);
        check({tag, " bcd"}, 32'(bcd), ref_bcd(int'(v)));
    endtask

    task automatic conv4(input logic [3:0] v, input string tag);
        int n;
        in_valid4 = 1'b1; bin4 = v;
        @(posedge clk); @(negedge clk);
        in_valid4 = 1'b0;
        wait4(n);
        check({tag, " latency"}, 32'(n + 1), 32'd5);
        check({tag, " bcd"}, 32'(bcd4), ref_bcd(int'(v)));
        out_ready4 = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready4 = 1'b0;
    endtask

    task automatic release8(input string tag);
        out_ready = 1'b1;
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check({tag, " valid_clear"}, 32'(out_valid), 32'd0);
        check({tag, " ready_back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        int n, c1, c2;
        logic [7:0] cnt;

        rst = 1'b0;
        in_valid = 1'b0; bin = '0; out_ready = 1'b0;
        in_valid4 = 1'b0; bin4 = '0; out_ready4 = 1'b0;

        // Reset state
        #13;
        check("rst in_ready", 32'(in_ready), 32'd0);
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst bcd", 32'(bcd), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        // 1: maximum value
        conv8(8'd255, "t1_255");
        check("t1 bcd_hex", 32'(bcd), 32'h255);
        check("t1 busy_done", 32'(busy), 32'd0);
        release8("t1");

        // 2: back-to-back 0 then 99 with out_ready held high; 99 is queued during SHIFT
        out_ready = 1'b1;
        in_valid = 1'b1; bin = 8'd0;
        @(posedge clk); @(negedge clk);
        bin = 8'd99;
        wait8(n);
        c1 = cyc;
        check("t2 bcd_0", 32'(bcd), 32'h000);
        @(posedge clk); @(negedge clk);
        check("t2 idle_ready", 32'(in_ready), 32'd1);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        wait8(n);
        c2 = cyc;
        check("t2 bcd_99", 32'(bcd), 32'h099);
        check("t2 period", 32'(c2 - c1), 32'd10);
        @(posedge clk); @(negedge clk);
        out_ready = 1'b0;
        check("t2 out_ready_idle", 32'(out_valid), 32'd0);

        // 3: backpressure on 128
        conv8(8'd128, "t3_128");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); @(negedge clk);
            check("t3 hold_valid", 32'(out_valid), 32'd1);
            check("t3 hold_bcd", 32'(bcd), 32'h128);
            check("t3 hold_ready", 32'(in_ready), 32'd0);
        end
        release8("t3");
        check("t3 bcd_kept", 32'(bcd), 32'h128);

        // 4: in-flight changes on in_valid/bin are ignored
        in_valid = 1'b1; bin = 8'd200;
        @(posedge clk); @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            in_valid = ~in_valid;
            bin = 8'($urandom_range(0, 255));
            @(posedge clk); @(negedge clk);
        end
        in_valid = 1'b0;
        wait8(n);
        check("t4 bcd_200", 32'(bcd), 32'h200);
        release8("t4");

        // 5: async reset during iteration 4
        in_valid = 1'b1; bin = 8'd150;
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); @(negedge clk); end
        check("t5 busy_mid", 32'(busy), 32'd1);
        #2 rst = 1'b0;
        #1;
        check("t5 rst_valid", 32'(out_valid), 32'd0);
        check("t5 rst_bcd", 32'(bcd), 32'd0);
        check("t5 rst_busy", 32'(busy), 32'd0);
        check("t5 rst_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        conv8(8'd37, "t5_37");
        check("t5 bcd_37", 32'(bcd), 32'h037);
        release8("t5");

        // 6: narrow instance, then live-counter sweep of both instances
        conv4(4'd15, "t6_w4_15");
        check("t6 w4 ready", 32'(in_ready4), 32'd1);
        for (int i = 0; i < 16; i++) conv4(4'(i), "t6_w4_sweep");

        cnt = 8'd0;
        for (int i = 0; i < 256; i++) begin
            conv8(cnt, "t6_sweep");
            release8("t6_sweep");
            cnt = cnt + 8'd1;
        end
        // counter wrap back to 0
        conv8(cnt, "t6_wrap");
        check("t6 wrap_bcd", 32'(bcd), 32'h000);
        release8("t6_wrap");

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
